kpn_pair_adder_process: RTL and testbench

- KPN process stage directly downstream of the precharged queue modules.
- Consumes the 16-bit token stream (output_1 / wr) and pairs consecutive tokens as A,B. Each pair produces one saturating sum token A+B.
- Result tokens go into an internal output FIFO, which the next queue/process stage reads through a rd/empty handshake.
- Tokens offered while the stage cannot accept them are counted, not silently lost.

---
 rtl/kpn_pair_adder_process_pkg.sv | 32 +++
 rtl/kpn_token_fifo.sv | 78 +++++++
 rtl/kpn_pair_adder_process.sv | 131 +++++++++++++
 tb/tb_kpn_pair_adder_process.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/kpn_pair_adder_process_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kpn_pair_adder_process_pkg
// Brief    : Shared KPN definitions: token width/type, pair-adder FSM state
//            encoding, saturation constant and a saturating-add helper.
// Revision : 1.0 - initial release
// ============================================================================
package kpn_pair_adder_process_pkg;

    // Default token width used across the KPN queue/process stages.
    localparam int KPN_BITS_NUMBER = 16;

    // A single KPN token.
    typedef logic [KPN_BITS_NUMBER-1:0] token_t;

    // Pair-adder FSM state encoding.
    localparam logic [1:0] c_WAIT_A = 2'd0;
    localparam logic [1:0] c_WAIT_B = 2'd1;
    localparam logic [1:0] c_PUSH   = 2'd2;

    // Value pushed when a sum overflows the token width.
    localparam token_t c_TOKEN_ONES = '1;

    // Saturating add at the default token width (carry forces all-ones).
    function automatic token_t sat_add(input token_t a, input token_t b);
        logic [KPN_BITS_NUMBER:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[KPN_BITS_NUMBER] ? c_TOKEN_ONES : s[KPN_BITS_NUMBER-1:0];
    endfunction

endpackage : kpn_pair_adder_process_pkg
`default_nettype wire

// File: rtl/kpn_token_fifo.sv
`default_nettype none
// ============================================================================
// Module   : kpn_token_fifo
// Brief    : First-word fall-through circular token FIFO with push/pop
//            arbitration. Full is judged before any same-edge pop, so a push
//            into a full FIFO is refused even if a pop frees a slot that edge.
// Revision : 1.0 - initial release
// ============================================================================
module kpn_token_fifo #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int                   c_DEPTH     = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0]   c_DEPTH_CNT = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [ADDR_BITS:0]   c_CNT_ONE   = {{ADDR_BITS{1'b0}}, 1'b1};
    localparam logic [ADDR_BITS-1:0] c_PTR_ONE   = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]     r_mem [c_DEPTH];
    logic [ADDR_BITS-1:0] r_w_ptr;
    logic [ADDR_BITS-1:0] r_r_ptr;
    logic [ADDR_BITS:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_push_ok;
    logic w_pop_ok;

    assign w_full    = (r_count == c_DEPTH_CNT);
    assign w_empty   = (r_count == '0);
    // Push on empty always wins; a pop on empty is simply ignored.
    assign w_push_ok = push & ~w_full;
    assign w_pop_ok  = pop & ~w_empty;

    assign full     = w_full;
    assign empty    = w_empty;
    // Head is presented combinationally; an empty FIFO reads as zero.
    assign pop_data = w_empty ? '0 : r_mem[r_r_ptr];

    // Storage write; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_w_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally modulo depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_w_ptr <= '0;
            r_r_ptr <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_w_ptr <= r_w_ptr + c_PTR_ONE;
            end
            if (w_pop_ok) begin
                r_r_ptr <= r_r_ptr + c_PTR_ONE;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : kpn_token_fifo
`default_nettype wire

// File: rtl/kpn_pair_adder_process.sv
`default_nettype none
// ============================================================================
// Module   : kpn_pair_adder_process
// Brief    : KPN process stage. Pairs consecutive input tokens A,B and pushes
//            the saturating sum A+B into an output token FIFO. Tokens offered
//            while the stage is busy are counted in a saturating drop counter.
// Revision : 1.0 - initial release
// ============================================================================
module kpn_pair_adder_process
    import kpn_pair_adder_process_pkg::*;
#(
    parameter int BITS_NUMBER   = KPN_BITS_NUMBER,
    parameter int FIFO_ELEMENTS = 3,
    parameter int DROP_CNT_BITS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [BITS_NUMBER-1:0]   in_data,
    input  logic                     in_wr,
    output logic                     in_rd,
    output logic [BITS_NUMBER-1:0]   out_data,
    output logic                     out_empty,
    output logic                     out_full,
    input  logic                     out_rd,
    output logic [DROP_CNT_BITS-1:0] drop_cnt
);

    localparam logic [DROP_CNT_BITS-1:0] c_DROP_ONE = {{(DROP_CNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [BITS_NUMBER-1:0]   c_SAT_ONES = {BITS_NUMBER{1'b1}};

    logic [1:0]               r_state;
    logic [1:0]               w_next_state;
    logic [BITS_NUMBER-1:0]   r_reg_a;
    logic [BITS_NUMBER-1:0]   r_reg_b;
    logic [BITS_NUMBER:0]     w_sum;
    logic [BITS_NUMBER-1:0]   w_push_data;
    logic                     w_in_rd;
    logic                     w_push_req;
    logic                     w_accept;
    logic                     w_drop;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic [DROP_CNT_BITS-1:0] r_drop_cnt;

    assign w_accept = in_wr & w_in_rd;
    assign w_drop   = in_wr & ~w_in_rd;

    // Sum one bit wider than a token; a carry saturates to all-ones.
    assign w_sum       = {1'b0, r_reg_a} + {1'b0, r_reg_b};
    assign w_push_data = w_sum[BITS_NUMBER] ? c_SAT_ONES : w_sum[BITS_NUMBER-1:0];

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_WAIT_A;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state: collect A, collect B, then retry the push until it fits.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_WAIT_A: if (w_accept)     w_next_state = c_WAIT_B;
            c_WAIT_B: if (w_accept)     w_next_state = c_PUSH;
            c_PUSH:   if (!w_fifo_full) w_next_state = c_WAIT_A;
            default:                    w_next_state = c_WAIT_A;
        endcase
    end

    // FSM outputs: ready while collecting operands, push request in PUSH.
    always_comb begin
        w_in_rd    = 1'b0;
        w_push_req = 1'b0;
        case (r_state)
            c_WAIT_A: w_in_rd    = 1'b1;
            c_WAIT_B: w_in_rd    = 1'b1;
            c_PUSH:   w_push_req = 1'b1;
            default: begin
                w_in_rd    = 1'b0;
                w_push_req = 1'b0;
            end
        endcase
    end

    // Operand capture; reset discards any half-formed pair.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reg_a <= '0;
            r_reg_b <= '0;
        end else begin
            if (w_accept && (r_state == c_WAIT_A)) begin
                r_reg_a <= in_data;
            end
            if (w_accept && (r_state == c_WAIT_B)) begin
                r_reg_b <= in_data;
            end
        end
    end

    // Refused-token counter, saturating at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + c_DROP_ONE;
        end
    end

    kpn_token_fifo #(
        .WIDTH     (BITS_NUMBER),
        .ADDR_BITS (FIFO_ELEMENTS)
    ) u_out_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push_req),
        .push_data (w_push_data),
        .pop       (out_rd),
        .pop_data  (out_data),
        .empty     (w_fifo_empty),
        .full      (w_fifo_full)
    );

    assign in_rd     = w_in_rd;
    assign out_empty = w_fifo_empty;
    assign out_full  = w_fifo_full;
    assign drop_cnt  = r_drop_cnt;

endmodule : kpn_pair_adder_process
`default_nettype wire

// File: tb/tb_kpn_pair_adder_process.sv
`default_nettype none
// ============================================================================
// Module   : tb_kpn_pair_adder_process
// Brief    : Self-checking bench for kpn_pair_adder_process. A reference
//            model tracks the pairing FSM, FIFO occupancy and drop count; a
//            scoreboard queue holds expected sums in order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kpn_pair_adder_process;

    localparam int c_DEPTH  = 8;
    localparam int c_M_A    = 0;
    localparam int c_M_B    = 1;
    localparam int c_M_PUSH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_wr = 1'b0;
    logic        in_rd;
    logic [15:0] out_data;
    logic        out_empty;
    logic        out_full;
    logic        out_rd = 1'b0;
    logic [7:0]  drop_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;

    logic [15:0] sb[$];
    int          m_state = c_M_A;
    logic [15:0] m_a = '0;
    int          m_cnt = 0;
    int          m_drop = 0;
    int          m_acc = 0;

    kpn_pair_adder_process #(
        .BITS_NUMBER   (16),
        .FIFO_ELEMENTS (3),
        .DROP_CNT_BITS (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_wr     (in_wr),
        .in_rd     (in_rd),
        .out_data  (out_data),
        .out_empty (out_empty),
        .out_full  (out_full),
        .out_rd    (out_rd),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sat(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // One clock: drive at the falling edge, check against the model, then
    // advance the model to what the next rising edge should produce.
    task automatic step(input logic wr, input logic [15:0] d, input logic rd);
        logic m_rd;
        logic m_push;
        logic m_pop;
        logic [15:0] popped;
        @(negedge clk);
        in_wr   = wr;
        in_data = d;
        out_rd  = rd;
        #1;
        m_rd = (m_state != c_M_PUSH);
        chk("in_rd", in_rd, m_rd);
        chk("out_empty", out_empty, m_cnt == 0);
        chk("out_full", out_full, m_cnt == c_DEPTH);
        chk("drop_cnt", drop_cnt, m_drop);
        if (m_cnt == 0) begin
            chk("out_data_empty", out_data, 0);
        end else if (sb.size() != 0) begin
            chk("out_data_head", out_data, sb[0]);
        end
        m_push = (m_state == c_M_PUSH) && (m_cnt != c_DEPTH);
        m_pop  = rd && (m_cnt != 0);
        if (m_pop && sb.size() != 0) begin
            popped = sb.pop_front();
            chk("pop_value", out_data, popped);
        end
        m_cnt = m_cnt + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
        if (wr && !m_rd && m_drop != 255) m_drop++;
        case (m_state)
            c_M_A: if (wr) begin m_a = d; m_acc++; m_state = c_M_B; end
            c_M_B: if (wr) begin sb.push_back(sat(m_a, d)); m_acc++; m_state = c_M_PUSH; end
            default: if (m_push) m_state = c_M_A;
        endcase
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic do_reset();
        @(negedge clk);
        in_wr  = 1'b0;
        out_rd = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_out_empty", out_empty, 1);
        chk("rst_out_full", out_full, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        sb.delete();
        m_state = c_M_A;
        m_a     = '0;
        m_cnt   = 0;
        m_drop  = 0;
        m_acc   = 0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_in_rd", in_rd, 1);
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] b;

        // Basic pair
        do_reset();
        step(1'b1, 16'h0001, 1'b0);
        step(1'b1, 16'h0002, 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        settle();
        chk("basic_sum", out_data, 16'h0003);
        chk("basic_not_empty", out_empty, 0);
        step(1'b0, 16'h0000, 1'b1);
        settle();
        chk("basic_popped_empty", out_empty, 1);

        // Saturation and the no-carry all-ones case
        step(1'b1, 16'hFFF0, 1'b0);
        step(1'b1, 16'h0020, 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        settle();
        chk("sat_carry", out_data, 16'hFFFF);
        step(1'b0, 16'h0000, 1'b1);
        step(1'b1, 16'h8000, 1'b0);
        step(1'b1, 16'h7FFF, 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        settle();
        chk("sat_nocarry", out_data, 16'hFFFF);
        step(1'b0, 16'h0000, 1'b1);

        // Half-formed pair discarded by reset
        step(1'b1, 16'h0055, 1'b0);
        do_reset();

        // Continuous stream 1..9
        for (int i = 1; i <= 9; i++) step(1'b1, 16'(i), 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        settle();
        chk("stream_drop", drop_cnt, 3);
        chk("stream_head", out_data, 16'h0003);
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 1'b1);
        chk("stream_sb_drained", sb.size(), 0);

        // Full / backpressure
        do_reset();
        for (int i = 0; i < 40 && m_acc < 18; i++) step(1'b1, 16'(i + 1), 1'b0);
        settle();
        chk("bp_full", out_full, 1);
        chk("bp_in_rd", in_rd, 0);
        for (int i = 0; i < 5; i++) step(1'b1, 16'hAAAA, 1'b0);
        step(1'b1, 16'h0001, 1'b1);
        step(1'b1, 16'h0002, 1'b0);
        settle();
        chk("bp_refill_full", out_full, 1);

        // Drop counter saturation
        for (int i = 0; i < 300; i++) step(1'b1, 16'(i), 1'b0);
        settle();
        chk("drop_sat", drop_cnt, 8'hFF);
        for (int i = 0; i < 3; i++) step(1'b1, 16'h1234, 1'b0);
        settle();
        chk("drop_sat_hold", drop_cnt, 8'hFF);
        for (int i = 0; i < 12; i++) step(1'b0, 16'h0000, 1'b1);
        chk("bp_sb_drained", sb.size(), 0);

        // Pointer wrap with concurrent push/pop
        do_reset();
        for (int i = 0; i < 20; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            step(1'b1, a, 1'b1);
            step(1'b1, b, 1'b1);
            step(1'b0, 16'h0000, 1'b1);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 1'b1);
        chk("wrap_sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_kpn_pair_adder_process
`default_nettype wire
